// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side request ports and SRAM-like bus signals shared by the memory bus arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory environment.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;
    logic        bus_err;
    logic        stall;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_be, data_addr, data_wdata,
               bus_addr_ok, bus_rdata, bus_data_ok,
        output inst_rdata, inst_done, data_rdata, data_done,
               bus_req, bus_wr, bus_be, bus_addr, bus_wdata, bus_err, stall
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_be, data_addr, data_wdata,
               bus_addr_ok, bus_rdata, bus_data_ok,
        input  inst_rdata, inst_done, data_rdata, data_done,
               bus_req, bus_wr, bus_be, bus_addr, bus_wdata, bus_err, stall
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports, one transaction at a time,
// with fixed data-over-fetch priority, per-port done pulses and a transaction timeout.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.master mb
);

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_WAIT,
        I_ADDR,
        I_WAIT
    } state_t;

    state_t      state;
    logic [31:0] wait_cnt;
    logic        is_data;
    logic        in_addr;
    logic        in_wait;
    logic        xfer_done;
    logic        timed_out;

    assign is_data   = (state == D_ADDR) || (state == D_WAIT);
    assign in_addr   = (state == D_ADDR) || (state == I_ADDR);
    assign in_wait   = (state == D_WAIT) || (state == I_WAIT);
    assign xfer_done = (in_addr && mb.bus_addr_ok && mb.bus_data_ok) || (in_wait && mb.bus_data_ok);

    // A normal completion in the same cycle as the deadline wins over the abort
    assign timed_out = (in_addr || in_wait) && (TIMEOUT != 0) &&
                       ((wait_cnt + 32'd1) == TIMEOUT) && !xfer_done;

    assign mb.stall = (mb.inst_req && !mb.inst_done) || (mb.data_req && !mb.data_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            mb.bus_req    <= 1'b0;
            mb.bus_wr     <= 1'b0;
            mb.bus_be     <= '0;
            mb.bus_addr   <= '0;
            mb.bus_wdata  <= '0;
            mb.bus_err    <= 1'b0;
            mb.inst_done  <= 1'b0;
            mb.data_done  <= 1'b0;
            mb.inst_rdata <= '0;
            mb.data_rdata <= '0;
        end else begin
            mb.inst_done <= 1'b0;
            mb.data_done <= 1'b0;
            mb.bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // A port whose done is high right now is finishing, not asking again
                    if (mb.data_req && !mb.data_done) begin
                        state        <= D_ADDR;
                        wait_cnt     <= '0;
                        mb.bus_req   <= 1'b1;
                        mb.bus_wr    <= mb.data_wr;
                        mb.bus_be    <= mb.data_wr ? mb.data_be : 4'hF;
                        mb.bus_addr  <= mb.data_addr;
                        mb.bus_wdata <= mb.data_wdata;
                    end else if (mb.inst_req && !mb.inst_done) begin
                        state        <= I_ADDR;
                        wait_cnt     <= '0;
                        mb.bus_req   <= 1'b1;
                        mb.bus_wr    <= 1'b0;
                        mb.bus_be    <= 4'hF;
                        mb.bus_addr  <= mb.inst_addr;
                        mb.bus_wdata <= '0;
                    end
                end
                default: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (xfer_done || timed_out) begin
                        state      <= IDLE;
                        mb.bus_req <= 1'b0;
                        mb.bus_err <= timed_out;
                        if (is_data) begin
                            mb.data_done  <= 1'b1;
                            mb.data_rdata <= timed_out ? 32'd0 : mb.bus_rdata;
                        end else begin
                            mb.inst_done  <= 1'b1;
                            mb.inst_rdata <= timed_out ? 32'd0 : mb.bus_rdata;
                        end
                    end else if (in_addr && mb.bus_addr_ok) begin
                        mb.bus_req <= 1'b0;
                        state      <= is_data ? D_WAIT : I_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: store, priority, slow address phase, minimum latency,
// timeout abort and reset in the middle of a transaction.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    mem_bus_arbiter_if mb ();

    mem_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .mb  (mb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        mb.inst_req    = 1'b0;
        mb.inst_addr   = '0;
        mb.data_req    = 1'b0;
        mb.data_wr     = 1'b0;
        mb.data_be     = '0;
        mb.data_addr   = '0;
        mb.data_wdata  = '0;
        mb.bus_addr_ok = 1'b0;
        mb.bus_rdata   = '0;
        mb.bus_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (mb.bus_req !== 1'b0) $display("[TB] FAIL reset_bus_req got %0h want 0", mb.bus_req); else passed++;
        total++; if (mb.bus_addr !== 32'h0) $display("[TB] FAIL reset_bus_addr got %0h want 0", mb.bus_addr); else passed++;
        total++; if ({mb.inst_done, mb.data_done, mb.bus_err} !== 3'b000)
            $display("[TB] FAIL reset_pulses got %b want 000", {mb.inst_done, mb.data_done, mb.bus_err}); else passed++;
        total++; if (mb.stall !== 1'b0) $display("[TB] FAIL reset_stall got %0h want 0", mb.stall); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store;
        mb.data_req = 1'b1; mb.data_wr = 1'b1; mb.data_be = 4'hF;
        mb.data_addr = 32'h8000_1000; mb.data_wdata = 32'hDEAD_BEEF;
        #1;
        total++; if (mb.stall !== 1'b1) $display("[TB] FAIL store_stall_c0 got %0h want 1", mb.stall); else passed++;
        tick();
        total++; if ({mb.bus_req, mb.bus_wr, mb.bus_be} !== 6'b11_1111)
            $display("[TB] FAIL store_ctrl got %b want 111111", {mb.bus_req, mb.bus_wr, mb.bus_be}); else passed++;
        total++; if (mb.bus_addr !== 32'h8000_1000) $display("[TB] FAIL store_addr got %h want 80001000", mb.bus_addr); else passed++;
        total++; if (mb.bus_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL store_wdata got %h want deadbeef", mb.bus_wdata); else passed++;
        mb.bus_addr_ok = 1'b1;
        tick();
        mb.bus_addr_ok = 1'b0;
        total++; if ({mb.bus_req, mb.data_done} !== 2'b00) $display("[TB] FAIL store_wait1 got %b want 00", {mb.bus_req, mb.data_done}); else passed++;
        tick();
        total++; if ({mb.bus_req, mb.data_done, mb.stall} !== 3'b001)
            $display("[TB] FAIL store_wait2 got %b want 001", {mb.bus_req, mb.data_done, mb.stall}); else passed++;
        mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'h0BAD_F00D;
        tick();
        mb.bus_data_ok = 1'b0;
        #1;
        total++; if ({mb.data_done, mb.stall} !== 2'b10) $display("[TB] FAIL store_done got %b want 10", {mb.data_done, mb.stall}); else passed++;
        total++; if (mb.bus_addr !== 32'h8000_1000) $display("[TB] FAIL store_addr_hold got %h want 80001000", mb.bus_addr); else passed++;
        tick();
        mb.data_req = 1'b0;
        total++; if ({mb.data_done, mb.bus_req} !== 2'b00) $display("[TB] FAIL store_one_pulse got %b want 00", {mb.data_done, mb.bus_req}); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_priority;
        mb.inst_req = 1'b1; mb.inst_addr = 32'h0000_1000;
        mb.data_req = 1'b1; mb.data_wr = 1'b0; mb.data_be = 4'b0011; mb.data_addr = 32'h0000_2000;
        tick();
        total++; if (mb.bus_addr !== 32'h0000_2000) $display("[TB] FAIL prio_data_first got %h want 00002000", mb.bus_addr); else passed++;
        total++; if ({mb.bus_req, mb.bus_wr, mb.bus_be} !== 6'b10_1111)
            $display("[TB] FAIL prio_load_ctrl got %b want 101111", {mb.bus_req, mb.bus_wr, mb.bus_be}); else passed++;
        mb.bus_addr_ok = 1'b1; mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'h1111_2222;
        tick();
        mb.bus_addr_ok = 1'b0; mb.bus_data_ok = 1'b0;
        total++; if ({mb.data_done, mb.inst_done, mb.bus_req} !== 3'b100)
            $display("[TB] FAIL prio_data_done got %b want 100", {mb.data_done, mb.inst_done, mb.bus_req}); else passed++;
        total++; if (mb.data_rdata !== 32'h1111_2222) $display("[TB] FAIL prio_data_rdata got %h want 11112222", mb.data_rdata); else passed++;
        tick();
        mb.data_req = 1'b0;
        total++; if ({mb.bus_req, mb.bus_be} !== 5'b1_1111) $display("[TB] FAIL prio_inst_grant got %b want 11111", {mb.bus_req, mb.bus_be}); else passed++;
        total++; if (mb.bus_addr !== 32'h0000_1000) $display("[TB] FAIL prio_inst_addr got %h want 00001000", mb.bus_addr); else passed++;
        mb.bus_addr_ok = 1'b1;
        tick();
        mb.bus_addr_ok = 1'b0;
        mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'h2402_0001;
        tick();
        mb.bus_data_ok = 1'b0;
        total++; if (mb.inst_done !== 1'b1) $display("[TB] FAIL prio_inst_done got %0h want 1", mb.inst_done); else passed++;
        total++; if (mb.inst_rdata !== 32'h2402_0001) $display("[TB] FAIL prio_inst_rdata got %h want 24020001", mb.inst_rdata); else passed++;
        tick();
        mb.inst_req = 1'b0;
        total++; if (mb.inst_done !== 1'b0) $display("[TB] FAIL prio_inst_pulse got %0h want 0", mb.inst_done); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_addr_delay;
        mb.data_req = 1'b1; mb.data_wr = 1'b1; mb.data_be = 4'b0101;
        mb.data_addr = 32'h0000_0300; mb.data_wdata = 32'hA5A5_A5A5;
        tick();
        for (int i = 1; i <= 4; i++) begin
            total++; if ({mb.bus_req, mb.bus_be} !== 5'b1_0101)
                $display("[TB] FAIL delay_req_be_c%0d got %b want 10101", i, {mb.bus_req, mb.bus_be}); else passed++;
            total++; if ({mb.bus_addr, mb.bus_wdata} !== {32'h0000_0300, 32'hA5A5_A5A5})
                $display("[TB] FAIL delay_fields_c%0d got %h_%h want 00000300_a5a5a5a5", i, mb.bus_addr, mb.bus_wdata); else passed++;
            if (i == 4) begin
                mb.bus_addr_ok = 1'b1; mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'h3333_4444;
            end
            tick();
        end
        mb.bus_addr_ok = 1'b0; mb.bus_data_ok = 1'b0;
        total++; if ({mb.bus_req, mb.data_done} !== 2'b01) $display("[TB] FAIL delay_done got %b want 01", {mb.bus_req, mb.data_done}); else passed++;
        tick();
        mb.data_req = 1'b0;
        total++; if ({mb.bus_req, mb.data_done} !== 2'b00) $display("[TB] FAIL delay_idle got %b want 00", {mb.bus_req, mb.data_done}); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_min_latency;
        mb.inst_req = 1'b1; mb.inst_addr = 32'h0000_0040;
        tick();
        total++; if (mb.bus_req !== 1'b1) $display("[TB] FAIL minlat_req got %0h want 1", mb.bus_req); else passed++;
        mb.bus_addr_ok = 1'b1; mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'hCAFE_F00D;
        tick();
        mb.bus_addr_ok = 1'b0; mb.bus_data_ok = 1'b0;
        total++; if ({mb.inst_done, mb.bus_req} !== 2'b10) $display("[TB] FAIL minlat_done got %b want 10", {mb.inst_done, mb.bus_req}); else passed++;
        total++; if (mb.inst_rdata !== 32'hCAFE_F00D) $display("[TB] FAIL minlat_rdata got %h want cafef00d", mb.inst_rdata); else passed++;
        tick();
        mb.inst_req = 1'b0;
        total++; if ({mb.inst_done, mb.bus_req} !== 2'b00) $display("[TB] FAIL minlat_after got %b want 00", {mb.inst_done, mb.bus_req}); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        mb.data_req = 1'b1; mb.data_wr = 1'b0; mb.data_addr = 32'h0000_0500;
        mb.inst_req = 1'b1; mb.inst_addr = 32'h0000_0600;
        mb.bus_rdata = 32'h7777_7777;
        tick();
        for (int k = 1; k <= 8; k++) begin
            total++; if ({mb.bus_err, mb.data_done} !== 2'b00)
                $display("[TB] FAIL timeout_early_c%0d got %b want 00", k, {mb.bus_err, mb.data_done}); else passed++;
            mb.bus_addr_ok = (k == 1);
            tick();
        end
        mb.bus_addr_ok = 1'b0;
        total++; if ({mb.bus_err, mb.data_done, mb.bus_req} !== 3'b110)
            $display("[TB] FAIL timeout_abort got %b want 110", {mb.bus_err, mb.data_done, mb.bus_req}); else passed++;
        total++; if (mb.data_rdata !== 32'h0) $display("[TB] FAIL timeout_rdata got %h want 0", mb.data_rdata); else passed++;
        tick();
        mb.data_req = 1'b0;
        total++; if ({mb.bus_err, mb.bus_req} !== 2'b01) $display("[TB] FAIL timeout_then_inst got %b want 01", {mb.bus_err, mb.bus_req}); else passed++;
        total++; if (mb.bus_addr !== 32'h0000_0600) $display("[TB] FAIL timeout_inst_addr got %h want 00000600", mb.bus_addr); else passed++;
        mb.bus_addr_ok = 1'b1; mb.bus_data_ok = 1'b1; mb.bus_rdata = 32'h0060_0600;
        tick();
        mb.bus_addr_ok = 1'b0; mb.bus_data_ok = 1'b0;
        total++; if (mb.inst_rdata !== 32'h0060_0600 || mb.inst_done !== 1'b1)
            $display("[TB] FAIL timeout_inst_done got %h/%0h want 00600600/1", mb.inst_rdata, mb.inst_done); else passed++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        mb.data_req = 1'b1; mb.data_wr = 1'b0; mb.data_addr = 32'h0000_0700;
        mb.bus_rdata = 32'h1234_5678;
        tick();
        total++; if (mb.bus_req !== 1'b1) $display("[TB] FAIL rstmid_req got %0h want 1", mb.bus_req); else passed++;
        mb.bus_addr_ok = 1'b1;
        tick();
        mb.bus_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        mb.data_req = 1'b0;
        mb.bus_data_ok = 1'b1;
        total++; if ({mb.bus_req, mb.bus_wr, mb.bus_be, mb.data_done, mb.bus_err} !== 8'h00)
            $display("[TB] FAIL rstmid_ctrl got %b want 00000000", {mb.bus_req, mb.bus_wr, mb.bus_be, mb.data_done, mb.bus_err}); else passed++;
        total++; if ({mb.bus_addr, mb.bus_wdata} !== 64'h0) $display("[TB] FAIL rstmid_bus got %h_%h want 0_0", mb.bus_addr, mb.bus_wdata); else passed++;
        total++; if ({mb.inst_rdata, mb.data_rdata} !== 64'h0)
            $display("[TB] FAIL rstmid_rdata got %h_%h want 0_0", mb.inst_rdata, mb.data_rdata); else passed++;
        tick();
        rst = 1'b0;
        total++; if (mb.data_done !== 1'b0) $display("[TB] FAIL rstmid_no_done got %0h want 0", mb.data_done); else passed++;
        tick();
        mb.bus_data_ok = 1'b0;
        total++; if ({mb.data_done, mb.bus_req} !== 2'b00) $display("[TB] FAIL rstmid_ignore_ok got %b want 00", {mb.data_done, mb.bus_req}); else passed++;
        clear_inputs();
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_store();
        test_priority();
        test_addr_delay();
        test_min_latency();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
